// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered one-hot decoder family.
package decoder_pkg;

  localparam int MAX_SEL_W = 5;
  localparam int MAX_Q_W   = 2 ** MAX_SEL_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  // Callers slice the result down to their own 2**SEL_W output width.
  function automatic logic [MAX_Q_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
    return {{(MAX_Q_W-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/reg_decoder_scan_if.sv
// Control and output bundle of reg_decoder_scan; state_dbg mirrors the FSM state.
interface reg_decoder_scan_if #(parameter int SEL_W = 2);
  import decoder_pkg::*;

  // No valid/ready pair here: en/mode are levels sampled every rising edge,
  // load is a single-cycle strobe, and every output is a registered level.
  logic                  en;
  logic                  mode;
  logic                  load;
  logic [SEL_W-1:0]      sel_in;
  logic [2**SEL_W-1:0]   q;
  logic [SEL_W-1:0]      q_idx;
  logic                  wrap;
  state_t                state_dbg;

  modport master (
    output en, mode, load, sel_in,
    input  q, q_idx, wrap, state_dbg
  );

  modport slave (
    input  en, mode, load, sel_in,
    output q, q_idx, wrap, state_dbg
  );

endinterface

// File: rtl/scan_divider.sv
// Free-running step divider: counts 0..SCAN_DIV-1 while enabled, tc marks the last count.
module scan_divider #(
  parameter int SCAN_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic cnt_en,
  output logic tc
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] TC_VAL = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] cnt;

  assign tc = (cnt == TC_VAL);

  // clr beats counting so a load restarts the step interval from zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt_en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/reg_decoder_scan.sv
// Registered N-to-2^N one-hot decoder with a direct-load mode and a divided auto-scan mode.
module reg_decoder_scan
  import decoder_pkg::*;
#(
  parameter int SEL_W    = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  reg_decoder_scan_if.slave   bus
);

  localparam int               Q_W     = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] IDX_MAX = '1;

  state_t           state;
  state_t           next_state;
  logic [SEL_W-1:0] idx_r;
  logic [Q_W-1:0]   q_r;
  logic             wrap_r;
  logic [SEL_W-1:0] idx_next;
  logic [Q_W-1:0]   q_next;
  logic             wrap_next;
  logic             div_clr;
  logic             div_run;
  logic             div_tc;

  scan_divider #(.SCAN_DIV(SCAN_DIV)) u_div (
    .clk    (clk),
    .rst    (rst),
    .clr    (div_clr),
    .cnt_en (div_run),
    .tc     (div_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The mode is taken straight from en/mode, so every edge acts on this
  // cycle's request and any state reaches any other in a single cycle.
  always_comb begin
    next_state = IDLE;
    if (bus.en) begin
      next_state = bus.mode ? SCAN : DIRECT;
    end
  end

  always_comb begin
    idx_next  = bus.load ? bus.sel_in : idx_r;
    wrap_next = 1'b0;
    div_clr   = 1'b1;
    div_run   = 1'b0;
    case (next_state)
      SCAN: begin
        div_clr = bus.load;
        div_run = 1'b1;
        // A load on the terminal count wins: no increment, no wrap.
        if (!bus.load && div_tc) begin
          idx_next  = idx_r + 1'b1;
          wrap_next = (idx_r == IDX_MAX);
        end
      end
      default: begin
      end
    endcase
    q_next = (next_state == IDLE) ? '0 : Q_W'(onehot(MAX_SEL_W'(idx_next)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r  <= '0;
      q_r    <= '0;
      wrap_r <= 1'b0;
    end else begin
      idx_r  <= idx_next;
      q_r    <= q_next;
      wrap_r <= wrap_next;
    end
  end

  assign bus.q         = q_r;
  assign bus.q_idx     = idx_r;
  assign bus.wrap      = wrap_r;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_reg_decoder_scan.sv
// Bench for reg_decoder_scan: a 2-bit/div-4 instance and a 3-bit/div-1 instance share one clock.
module tb_reg_decoder_scan;
  import decoder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2;
  logic rst3;

  reg_decoder_scan_if #(.SEL_W(2)) bus2 ();
  reg_decoder_scan_if #(.SEL_W(3)) bus3 ();

  reg_decoder_scan #(.SEL_W(2), .SCAN_DIV(4)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2.slave)
  );

  reg_decoder_scan #(.SEL_W(3), .SCAN_DIV(1)) dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3.slave)
  );

  // ---------------- scoreboard state ----------------
  logic [6:0]  exp_q[$];   // {q[3:0], q_idx[1:0], wrap}
  logic [11:0] exp3_q[$];  // {q[7:0], q_idx[2:0], wrap}
  logic [6:0]  e2;
  logic [11:0] e3;
  int          checks = 0;
  int          errors = 0;
  bit          inv_on = 1'b0;
  bit          done   = 1'b0;

  // ---------------- driver tasks ----------------
  task automatic cyc2(input logic r, input logic e, input logic m, input logic l,
                      input logic [1:0] s, input logic [3:0] eq,
                      input logic [1:0] ei, input logic ew);
    @(negedge clk);
    rst2        = r;
    bus2.en     = e;
    bus2.mode   = m;
    bus2.load   = l;
    bus2.sel_in = s;
    exp_q.push_back({eq, ei, ew});
  endtask

  task automatic cyc3(input logic r, input logic e, input logic m, input logic l,
                      input logic [2:0] s, input logic [7:0] eq,
                      input logic [2:0] ei, input logic ew);
    @(negedge clk);
    rst3        = r;
    bus3.en     = e;
    bus3.mode   = m;
    bus3.load   = l;
    bus3.sel_in = s;
    exp3_q.push_back({eq, ei, ew});
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e2 = exp_q.pop_front();
      checks++;
      if ({bus2.q, bus2.q_idx, bus2.wrap} !== e2) begin
        errors++;
        $display("FAIL dut2_out @%0t: got q=%b idx=%0d wrap=%b, want q=%b idx=%0d wrap=%b",
                 $time, bus2.q, bus2.q_idx, bus2.wrap, e2[6:3], e2[2:1], e2[0]);
      end
    end
    if (exp3_q.size() > 0) begin
      e3 = exp3_q.pop_front();
      checks++;
      if ({bus3.q, bus3.q_idx, bus3.wrap} !== e3) begin
        errors++;
        $display("FAIL dut3_out @%0t: got q=%b idx=%0d wrap=%b, want q=%b idx=%0d wrap=%b",
                 $time, bus3.q, bus3.q_idx, bus3.wrap, e3[11:4], e3[3:1], e3[0]);
      end
    end
    if (inv_on) begin
      checks++;
      if (!(bus3.q == 8'd0 || bus3.q == (8'd1 << bus3.q_idx))) begin
        errors++;
        $display("FAIL dut3_onehot @%0t: got q=%b idx=%0d, want zero or 1<<idx",
                 $time, bus3.q, bus3.q_idx);
      end
    end
    if (done) begin
      checks++;
      if (exp_q.size() != 0 || exp3_q.size() != 0) begin
        errors++;
        $display("FAIL queue_drain: got %0d/%0d pending, want 0/0",
                 exp_q.size(), exp3_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test by %0t, want finish", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst2 = 1'b1; bus2.en = 1'b0; bus2.mode = 1'b0; bus2.load = 1'b0; bus2.sel_in = '0;
    rst3 = 1'b1; bus3.en = 1'b0; bus3.mode = 1'b0; bus3.load = 1'b0; bus3.sel_in = '0;

    // Reset dominates en/mode/load.
    cyc2(1, 1, 1, 1, 2'd3, 4'b0000, 2'd0, 0);
    cyc2(1, 1, 1, 1, 2'd3, 4'b0000, 2'd0, 0);

    // Direct decode, idle blanking, idle load, retained index on re-entry.
    cyc2(0, 1, 0, 1, 2'd2, 4'b0100, 2'd2, 0);
    cyc2(0, 1, 0, 0, 2'd0, 4'b0100, 2'd2, 0);
    cyc2(0, 1, 0, 1, 2'd3, 4'b1000, 2'd3, 0);
    cyc2(0, 1, 0, 0, 2'd0, 4'b1000, 2'd3, 0);
    cyc2(0, 0, 0, 0, 2'd0, 4'b0000, 2'd3, 0);
    cyc2(0, 0, 1, 0, 2'd0, 4'b0000, 2'd3, 0);
    cyc2(0, 0, 0, 1, 2'd1, 4'b0000, 2'd1, 0);
    cyc2(0, 1, 0, 0, 2'd0, 4'b0010, 2'd1, 0);
    cyc2(0, 1, 0, 1, 2'd0, 4'b0001, 2'd0, 0);

    // Scan from idx 0: one step every 4th edge, wrap on the return to 0001.
    for (int k = 0; k < 31; k++) begin
      cyc2(0, 1, 1, 0, 2'd0, 4'b0001 << ((k + 1) / 4 % 4), 2'((k + 1) / 4 % 4), k == 15);
    end
    // idx=3 with divider at terminal count: load wins, no wrap.
    cyc2(0, 1, 1, 1, 2'd1, 4'b0010, 2'd1, 0);
    cyc2(0, 1, 1, 0, 2'd0, 4'b0010, 2'd1, 0);
    cyc2(0, 1, 1, 0, 2'd0, 4'b0010, 2'd1, 0);
    cyc2(0, 1, 1, 0, 2'd0, 4'b0010, 2'd1, 0);
    cyc2(0, 1, 1, 0, 2'd0, 4'b0100, 2'd2, 0);

    // Mode switch holds the index; reset mid-scan beats a load.
    cyc2(0, 1, 0, 0, 2'd0, 4'b0100, 2'd2, 0);
    cyc2(0, 1, 0, 0, 2'd0, 4'b0100, 2'd2, 0);
    cyc2(0, 1, 1, 0, 2'd0, 4'b0100, 2'd2, 0);
    cyc2(0, 1, 1, 0, 2'd0, 4'b0100, 2'd2, 0);
    cyc2(1, 1, 1, 1, 2'd3, 4'b0000, 2'd0, 0);
    cyc2(0, 0, 0, 0, 2'd0, 4'b0000, 2'd0, 0);

    // SEL_W=3, SCAN_DIV=1: index advances every edge, wrap once per 8.
    cyc3(1, 1, 1, 0, 3'd0, 8'd0, 3'd0, 0);
    inv_on = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc3(0, 1, 1, 0, 3'd0, 8'd1 << ((k + 1) % 8), 3'((k + 1) % 8), (k % 8) == 7);
    end

    @(negedge clk);
    @(negedge clk);
    done = 1'b1;
  end

endmodule

// File: doc/reg_decoder_scan.md
Name: reg_decoder_scan

Overview:
- Registered, parametrised N-to-2^N one-hot decoder, successor to the combinational two-bit decoder.
- Direct mode: decodes a loaded select value into a held one-hot output.
- Scan mode: steps its own index through all outputs at a divided rate, e.g. to drive display digit strobes or round-robin enables.
- Sits between control logic and one-hot select lines; all outputs are registered.

Parameters:
- SEL_W, 2: select/index width; the output is 2**SEL_W bits wide. Legal range 1..5.
- SCAN_DIV, 4: clock cycles per scan step. Must be at least 1.
- DIV_W, derived as max(1, $clog2(SCAN_DIV)): width of the divider counter. Localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; 0 forces the one-hot output to zero.
- mode  in  1  0 = direct decode, 1 = auto-scan.
- load  in  1  one-cycle strobe; captures sel_in into the index.
- sel_in  in  SEL_W  select value captured on load.
- q  out  2**SEL_W  registered one-hot output.
- q_idx  out  SEL_W  registered current index.
- wrap  out  1  one-cycle pulse when the scan index wraps from max to 0.

Behaviour:
- Reset (rst=1 at a clock edge), dominant over all other inputs:
  - q=0, q_idx=0, wrap=0, divider=0, state=IDLE.
  - Applies identically mid-scan or mid-load.
- States:
  - IDLE: en=0.
  - DIRECT: en=1, mode=0.
  - SCAN: en=1, mode=1.
  - The next state is evaluated every cycle from en/mode, so any state can reach any other in one cycle.
- IDLE:
  - q<=0, wrap<=0, divider<=0.
  - q_idx holds, except load still captures sel_in into q_idx.
- DIRECT:
  - load=1: q_idx<=sel_in and q<=(1<<sel_in). One-cycle latency from load to q.
  - load=0: q<=(1<<q_idx), so on entry from IDLE or SCAN, q shows the retained index one cycle later.
  - wrap stays 0; divider stays 0.
- SCAN:
  - Divider counts 0..SCAN_DIV-1.
  - At terminal count (divider==SCAN_DIV-1): divider<=0 and q_idx<=q_idx+1 modulo 2**SEL_W.
  - If q_idx was 2**SEL_W-1 at that step, wrap<=1 for exactly one cycle; otherwise wrap<=0.
  - q<=(1<<next q_idx), so q and q_idx always change on the same edge.
  - SCAN_DIV=1: index advances every cycle and wrap pulses once per 2**SEL_W cycles.
- Entering SCAN from IDLE or DIRECT: divider starts at 0, and the first step occurs SCAN_DIV cycles after entry.
- load in SCAN: q_idx<=sel_in, q<=(1<<sel_in), divider<=0, wrap<=0.
  - If load coincides with terminal count, load wins: no increment and no wrap.
- Invariants:
  - q is all-zero or exactly one-hot.
  - Whenever q!=0, q equals 1<<q_idx.
  - wrap is never high two cycles in a row unless SCAN_DIV=1 and SEL_W... never, since SEL_W>=1 gives at least 2 indices.
- Index arithmetic is unsigned SEL_W-bit with natural wrap. No X propagation is allowed out of reset.

Decomposition:
- Shared package decoder_pkg holds:
  - the state enum {IDLE, DIRECT, SCAN};
  - function onehot(idx), returning the 2**SEL_W-bit value 1<<idx.
- One natural sub-module: scan_divider (DIV_W counter with clear input and terminal-count output), also reusable by the display driver.
- The top level contains the state register, the index register and the output registers.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1, mode=1 -> q=0000, q_idx=0, wrap=0 on the first edge after rst rises.
- Direct decode: en=1, mode=0, load with sel_in=2 -> the next cycle q=0100, q_idx=2. Then load sel_in=3 -> q=1000. Then en=0 -> q=0000 one cycle later with q_idx=3 retained.
- Scan order (SCAN_DIV=4): en=1, mode=1 from q_idx=0 -> q steps 0001, 0010, 0100, 1000, 0001 every 4 cycles. wrap=1 only on the cycle q returns to 0001.
- Load vs terminal-count collision: in scan at q_idx=3, divider=3, assert load with sel_in=1 -> q=0010, q_idx=1, wrap stays 0, and the next step comes 4 cycles later (q=0100).
- Mid-operation reset and mode switch: scanning at q_idx=2, switch mode to 0 -> q stays 0100. Then assert rst during a later scan -> q=0000 and q_idx=0 regardless of load.
- Parameter sweep: SEL_W=3, SCAN_DIV=1 -> q walks all 8 one-hot values on consecutive cycles, with wrap once every 8 cycles and the one-hot invariant checked on every cycle.
